// File: rtl/mix_digest.sv
// Folds an eight-word state snapshot into a 32-bit digest by rotate-and-add,
// one word per cycle, then holds the result until downstream takes it.
module mix_digest #(
    parameter int unsigned ROT = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [255:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [31:0]  out_digest,
    output logic [15:0]  out_count,
    input  logic         out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        OUT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [7:0][31:0]  words_q, words_d;
    logic [31:0]       acc_q, acc_d;
    logic [2:0]        idx_q, idx_d;
    logic [15:0]       count_q, count_d;

    // A shift of 32 yields zero, so ROT=0 degenerates cleanly to the identity.
    function automatic logic [31:0] rotl(input logic [31:0] x);
        return (x << ROT) | (x >> (32 - ROT));
    endfunction

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        words_d = words_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        count_d = count_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    words_d = in_data;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                acc_d = rotl(acc_q) + words_q[idx_q];
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                // Returning to IDLE here means no accept can share this edge.
                if (out_ready) begin
                    state_d = IDLE;
                    count_d = count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the word latches are ordinary flops and are cleared on reset like the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            words_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            words_q <= words_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == OUT);
    assign out_digest = acc_q;
    assign out_count  = count_q;

endmodule

// File: tb/tb_mix_digest.sv
// Directed bench for mix_digest: hand-computed digests, latency, backpressure,
// mid-fold reset and counter wrap.
module tb_mix_digest;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [255:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [31:0]  out_digest;
    logic [15:0]  out_count;
    logic         out_ready;

    int n_cmp = 0;
    int n_err = 0;

    mix_digest #(.ROT(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_digest (out_digest),
        .out_count  (out_count),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a snapshot, scramble in_data afterwards, wait for the digest and hand it off.
    task automatic run_digest(input logic [255:0] data, input logic [31:0] exp,
                              input logic [15:0] exp_cnt, input logic hold_ready,
                              input string tag);
        int n;
        out_ready = hold_ready;
        in_data   = data;
        in_valid  = 1'b1;
        tick();
        chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        in_data  = ~data;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 32'd8);
        chk({tag, "_digest"}, out_digest, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_vld_low"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rdy_high"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_count"}, {16'd0, out_count}, {16'd0, exp_cnt});
    endtask

    logic [255:0] v;
    logic [31:0]  acc_tbl [8];

    initial begin
        acc_tbl = '{32'h00000001, 32'h00000021, 32'h00000421, 32'h00008421,
                    32'h00108421, 32'h02108421, 32'h42108421, 32'h42108429};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #3;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_digest", out_digest, 32'h0);
        chk("rst_count", {16'd0, out_count}, 32'd0);
        #9 rst_n = 1'b1;

        // First posedge after release accepts; out_ready held high throughout.
        run_digest('0, 32'h00000000, 16'd1, 1'b1, "zero");

        v = '0; v[31:0] = 32'h1;
        run_digest(v, 32'h00000008, 16'd2, 1'b0, "w0");

        v = '0; v[255:224] = 32'h1;
        run_digest(v, 32'h00000001, 16'd3, 1'b0, "w7");

        // All ones, checking every intermediate accumulator value.
        in_data  = {8{32'h1}};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ones_vld_%0d", i), {31'd0, out_valid}, 32'd0);
            tick();
            chk($sformatf("ones_acc_%0d", i), out_digest, acc_tbl[i]);
        end
        chk("ones_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ones_count", {16'd0, out_count}, 32'd4);

        // Backpressure: digest of word1=1 is 1 rotated by 30 = 0x40000000.
        v = '0; v[63:32] = 32'h1;
        in_data  = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        v = '0; v[255:224] = 32'h1;
        in_data  = v;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_digest_%0d", i), out_digest, 32'h40000000);
            chk($sformatf("bp_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_handshake_idle", {31'd0, in_ready}, 32'd1);
        chk("bp_count", {16'd0, out_count}, 32'd5);
        tick();
        chk("bp_accept_next", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_second_digest", out_digest, 32'h00000001);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_second_count", {16'd0, out_count}, 32'd6);

        // Reset during the fourth fold cycle abandons the digest.
        in_data  = {8{32'h1}};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_count", {16'd0, out_count}, 32'd0);
        chk("mid_rst_digest", out_digest, 32'h0);
        #2 rst_n = 1'b1;
        run_digest('0, 32'h00000000, 16'd1, 1'b0, "post_rst");

        // Counter wrap: preload 0xFFFF, one more handshake must give 0x0000.
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        #1;
        v = '0; v[31:0] = 32'h1;
        run_digest(v, 32'h00000008, 16'h0000, 1'b0, "wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
